cordic_req_sequencer: RTL and testbench

- Initiator-side front end for the 8-stage CORDIC core.
- The core has no valid or handshake signals. This block provides a valid/ready request interface and drives the core's op_mode, x, y and rotate inputs one request per cycle.
- It tracks in-flight operations with a latency-matched valid/op shift register and captures the core's two outputs into a response FIFO.
- It uses credit-based flow control, so the FIFO can never overflow even though the core pipeline cannot stall.

---
 rtl/cordic_req_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cordic_req_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_req_sequencer.sv
// Valid/ready front end for the handshake-free 8-stage CORDIC core: issues requests, tracks them
// through a latency-matched pipe and queues results. Optional stats: define CORDIC_SEQ_STATS_EN.
module cordic_req_sequencer #(
   parameter int unsigned LATENCY    = 10,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DW         = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_op,
   input  logic [DW-1:0]                    req_x,
   input  logic [DW-1:0]                    req_y,
   input  logic [DW-1:0]                    req_angle,
   output logic                             core_op_mode,
   output logic [DW-1:0]                    core_x,
   output logic [DW-1:0]                    core_y,
   output logic [DW-1:0]                    core_rot,
   input  logic [DW-1:0]                    core_out0,
   input  logic [DW-1:0]                    core_out1,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic                             rsp_op,
   output logic [DW-1:0]                    rsp_a,
   output logic [DW-1:0]                    rsp_b,
   output logic [$clog2(LATENCY+1)-1:0]     inflight,
   output logic                             busy
`ifdef CORDIC_SEQ_STATS_EN
   ,
   output logic [15:0]                      stat_issued,
   output logic [15:0]                      stat_dropped
`endif
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned NW  = AW + 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IW  = $clog2(LATENCY + 1);
   // The issue register adds one more op in flight than the pipe alone holds.
   localparam int unsigned IWI = $clog2(LATENCY + 2);
   localparam int unsigned EW  = 2 * DW + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StFlush = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      credit_q, credit_d;
   logic [IWI-1:0]     inflight_q, inflight_d;
   logic               issue_vld_q;
   logic               core_op_q;
   logic [DW-1:0]      core_x_q, core_y_q, core_rot_q;
   logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
   logic [LATENCY-1:0] op_pipe_q, op_pipe_d;

   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]      count_q;
   logic [EW-1:0]      head;

   logic accept, tail_vld, in_flush, push, drop, pop, flush_done, fifo_nempty;

   assign in_flush    = (state_q == StFlush);
   assign fifo_nempty = (count_q != '0);
   assign req_ready   = reset && (state_q == StIdle || state_q == StRun) && (credit_q != '0)
                        && !flush;
   assign accept      = req_valid && req_ready;
   assign tail_vld    = vld_pipe_q[LATENCY-1];
   assign push        = tail_vld && !in_flush;
   assign drop        = tail_vld && in_flush;
   assign rsp_valid   = fifo_nempty && !in_flush;
   assign pop         = rsp_valid && rsp_ready;
   assign flush_done  = in_flush && (inflight_q == '0);

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StFlush;
      end else begin
         case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (inflight_q == '0 && !accept) state_d = StIdle;
            StFlush: if (inflight_q == '0) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      credit_d = credit_q;
      if (flush_done) begin
         credit_d = CW'(FIFO_DEPTH);
      end else begin
         credit_d = credit_q + CW'(pop) + CW'(drop) - CW'(accept);
      end
      inflight_d = inflight_q + IWI'(accept) - IWI'(tail_vld);
   end

   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      op_pipe_d     = op_pipe_q;
      vld_pipe_d[0] = issue_vld_q;
      op_pipe_d[0]  = core_op_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         op_pipe_d[i]  = op_pipe_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         credit_q    <= CW'(FIFO_DEPTH);
         inflight_q  <= '0;
         issue_vld_q <= 1'b0;
         core_op_q   <= 1'b0;
         core_x_q    <= '0;
         core_y_q    <= '0;
         core_rot_q  <= '0;
         vld_pipe_q  <= '0;
         op_pipe_q   <= '0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         inflight_q  <= inflight_d;
         issue_vld_q <= accept;
         // Core inputs return to zero whenever nothing is issued.
         core_op_q   <= accept ? req_op    : 1'b0;
         core_x_q    <= accept ? req_x     : '0;
         core_y_q    <= accept ? req_y     : '0;
         core_rot_q  <= accept ? req_angle : '0;
         vld_pipe_q  <= vld_pipe_d;
         op_pipe_q   <= op_pipe_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_done) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + NW'(push) - NW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {op_pipe_q[LATENCY-1], core_out0, core_out1};
   end

   assign head         = mem_q[rd_ptr_q];
   assign rsp_op       = rsp_valid ? head[EW-1]        : 1'b0;
   assign rsp_a        = rsp_valid ? head[2*DW-1:DW]   : '0;
   assign rsp_b        = rsp_valid ? head[DW-1:0]      : '0;
   assign core_op_mode = core_op_q;
   assign core_x       = core_x_q;
   assign core_y       = core_y_q;
   assign core_rot     = core_rot_q;
   assign inflight     = inflight_q[IW-1:0];
   assign busy         = (state_q != StIdle) || (inflight_q != '0) || fifo_nempty;

`ifdef CORDIC_SEQ_STATS_EN
   logic [15:0] stat_issued_q, stat_dropped_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_issued_q  <= '0;
         stat_dropped_q <= '0;
      end else begin
         if (accept) stat_issued_q  <= stat_issued_q + 16'd1;
         if (drop)   stat_dropped_q <= stat_dropped_q + 16'd1;
      end
   end

   assign stat_issued  = stat_issued_q;
   assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_cordic_req_sequencer.sv
// Bench for cordic_req_sequencer with a delay-line core stub (out0 = x + 1, out1 = y + 2).
// Stats checks are compiled in when CORDIC_SEQ_STATS_EN is defined.
module tb_cordic_req_sequencer;

   localparam int unsigned LAT   = 10;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned DW    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_op = 1'b0;
   logic [DW-1:0] req_x = '0, req_y = '0, req_angle = '0;
   logic          core_op_mode;
   logic [DW-1:0] core_x, core_y, core_rot, core_out0, core_out1;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_op;
   logic [DW-1:0] rsp_a, rsp_b;
   logic [3:0]    inflight;
   logic          busy;
`ifdef CORDIC_SEQ_STATS_EN
   logic [15:0]   stat_issued, stat_dropped;
`endif

   cordic_req_sequencer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DW(DW)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
      .core_op_mode(core_op_mode), .core_x(core_x), .core_y(core_y), .core_rot(core_rot),
      .core_out0(core_out0), .core_out1(core_out1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_a(rsp_a), .rsp_b(rsp_b), .inflight(inflight), .busy(busy)
`ifdef CORDIC_SEQ_STATS_EN
      , .stat_issued(stat_issued), .stat_dropped(stat_dropped)
`endif
   );

   always #5 clock = ~clock;

   // Core stub: samples inputs each edge, results visible LAT cycles after the sample edge.
   logic [DW-1:0] dx [LAT];
   logic [DW-1:0] dy [LAT];
   always @(posedge clock) begin
      dx[0] <= core_x;
      dy[0] <= core_y;
      for (int i = 1; i < LAT; i++) begin
         dx[i] <= dx[i-1];
         dy[i] <= dy[i-1];
      end
   end
   assign core_out0 = dx[LAT-1] + 16'd1;
   assign core_out1 = dy[LAT-1] + 16'd2;

   typedef struct packed {
      logic          op;
      logic [15:0]   x, y, ang, ea, eb;
   } vec_t;

   int            n_checks = 0;
   int            n_fail = 0;
   int            n_acc, n_pop;
   logic [15:0]   next_x;
   logic [16:0]   exp_q [$];
   vec_t          vt [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One cycle of streaming traffic; the scoreboard follows accepts and pops.
   task automatic cycle_io(input logic rv, input logic rr);
      step();
      req_valid = rv; req_op = next_x[0]; req_x = next_x; req_y = '0; req_angle = '0;
      rsp_ready = rr;
      #1;
      if (rv && req_ready) begin
         exp_q.push_back({next_x[0], next_x + 16'd1});
         next_x = next_x + 16'd1;
         n_acc++;
      end
      if (rr && rsp_valid) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL pop_unexpected: got a=%0h expected no response", rsp_a);
         end else begin
            check("stream_a", rsp_a, exp_q[0][15:0]);
            check("stream_op", rsp_op, exp_q[0][16]);
            check("stream_b", rsp_b, 16'h0002);
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic run_single(input logic [15:0] x, y, ang, input logic op,
                             input logic [15:0] ea, eb);
      logic early;
      step();
      req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_angle = ang; rsp_ready = 1'b0;
      #1;
      check("single_ready", req_ready, 1'b1);
      step();                                   // cycle 1
      req_valid = 1'b0;
      #1;
      check("single_core_rot", core_rot, ang);
      check("single_core_x", core_x, x);
      check("single_core_op", core_op_mode, op);
      check("single_inflight", inflight, 4'd1);
      early = 1'b0;
      for (int c = 2; c <= 11; c++) begin
         step(); #1;
         if (c == 2) check("single_core_idle", core_x, 16'h0000);
         if (rsp_valid) early = 1'b1;
      end
      check("single_early", early, 1'b0);
      step(); #1;                               // cycle 12
      check("single_valid", rsp_valid, 1'b1);
      check("single_a", rsp_a, ea);
      check("single_b", rsp_b, eb);
      check("single_op", rsp_op, op);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      check("single_popped", rsp_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int got;
      logic bad;
`ifdef CORDIC_SEQ_STATS_EN
      logic [15:0] iss0;
`endif
      vt[0] = '{1'b0, 16'h1234, 16'h00FF, 16'h0010, 16'h1235, 16'h0101};
      vt[1] = '{1'b1, 16'h8100, 16'h0200, 16'hFFFF, 16'h8101, 16'h0202};
      vt[2] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
      vt[3] = '{1'b1, 16'h0000, 16'hFFFE, 16'h1111, 16'h0001, 16'h0000};
      vt[4] = '{1'b0, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8002};
      vt[5] = '{1'b1, 16'h00FF, 16'h00FF, 16'h0000, 16'h0100, 16'h0101};

      // Reset state
      step(); step(); #1;
      check("rst_core_x", core_x, 16'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_inflight", inflight, 4'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      step();
      reset = 1'b1;
      #1;
      check("idle_req_ready", req_ready, 1'b1);
`ifdef CORDIC_SEQ_STATS_EN
      check("rst_stat_issued", stat_issued, 16'h0);
`endif

      run_single(16'h0100, 16'h0000, 16'h0192, 1'b0, 16'h0101, 16'h0002);

      // Table of back-to-back requests
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         req_valid = 1'b1; req_op = vt[i].op; req_x = vt[i].x; req_y = vt[i].y;
         req_angle = vt[i].ang;
         #1;
         check("tbl_ready", req_ready, 1'b1);
         if (i > 0) begin
            check("tbl_core_x", core_x, vt[i-1].x);
            check("tbl_core_rot", core_rot, vt[i-1].ang);
            check("tbl_core_op", core_op_mode, vt[i-1].op);
         end
      end
      step();
      req_valid = 1'b0;
      #1;
      check("tbl_core_y", core_y, vt[5].y);
      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         step(); #1;
         if (rsp_valid) begin
            check("tbl_rsp_a", rsp_a, vt[got].ea);
            check("tbl_rsp_b", rsp_b, vt[got].eb);
            check("tbl_rsp_op", rsp_op, vt[got].op);
            got++;
         end
      end
      check("tbl_count", got, 6);

      // 20 mixed ops with toggling rsp_ready
      next_x = '0; n_acc = 0; n_pop = 0;
      for (int c = 0; c < 100 && (n_acc < 20 || n_pop < 20); c++) begin
         cycle_io(n_acc < 20, (c % 2) == 1);
      end
      check("mixed_accepts", n_acc, 20);
      check("mixed_pops", n_pop, 20);

      // Backpressure: exactly DEPTH accepts, then one per pop
      n_acc = 0;
      for (int c = 0; c < 40; c++) cycle_io(1'b1, 1'b0);
      check("bp_accepts", n_acc, 16);
      check("bp_ready_low", req_ready, 1'b0);
      check("bp_inflight", inflight, 4'd0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      cycle_io(1'b1, 1'b1);
      n_acc = 0;
      for (int c = 0; c < 30; c++) cycle_io(1'b1, 1'b0);
      check("bp_one_more", n_acc, 1);

      // Streaming with a full FIFO: pop and push overlap
      for (int c = 0; c < 40; c++) cycle_io(1'b1, 1'b1);
      for (int c = 0; c < 60 && (exp_q.size() != 0 || busy); c++) cycle_io(1'b0, 1'b1);
      check("drain_empty", exp_q.size(), 0);
      check("drain_busy", busy, 1'b0);

      // Flush with 3 queued and 5 in flight
`ifdef CORDIC_SEQ_STATS_EN
      iss0 = stat_issued;
`endif
      for (int k = 0; k < 14; k++) cycle_io((k < 3) || (k >= 8 && k < 13), 1'b0);
      step();                                   // cycle 14
      req_valid = 1'b0; flush = 1'b1;
      #1;
      check("fl_inflight5", inflight, 4'd5);
      check("fl_queued_valid", rsp_valid, 1'b1);
      check("fl_ready_low", req_ready, 1'b0);
      bad = 1'b0;
      for (int k = 15; k <= 24; k++) begin
         step();
         flush = 1'b0;
         #1;
         if (rsp_valid || req_ready) bad = 1'b1;
         if (k == 24) begin
            check("fl_inflight0", inflight, 4'd0);
            check("fl_busy", busy, 1'b1);
         end
      end
      check("fl_quiet", bad, 1'b0);
      step(); #1;                               // cycle 25
      check("fl_idle_busy", busy, 1'b0);
      check("fl_idle_ready", req_ready, 1'b1);
      check("fl_idle_valid", rsp_valid, 1'b0);
`ifdef CORDIC_SEQ_STATS_EN
      check("fl_stat_issued", stat_issued - iss0, 16'd8);
      check("fl_stat_dropped", stat_dropped, 16'd5);
`endif
      exp_q.delete();
      n_acc = 0;
      for (int c = 0; c < 40; c++) cycle_io(1'b1, 1'b0);
      check("fl_credits", n_acc, 16);

      // Asynchronous reset mid-burst
      for (int c = 0; c < 5; c++) cycle_io(1'b1, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check("ar_core_x", core_x, 16'h0);
      check("ar_core_y", core_y, 16'h0);
      check("ar_core_rot", core_rot, 16'h0);
      check("ar_core_op", core_op_mode, 1'b0);
      check("ar_rsp_valid", rsp_valid, 1'b0);
      check("ar_rsp_a", rsp_a, 16'h0);
      check("ar_rsp_b", rsp_b, 16'h0);
      check("ar_rsp_op", rsp_op, 1'b0);
      check("ar_inflight", inflight, 4'd0);
      check("ar_busy", busy, 1'b0);
      check("ar_req_ready", req_ready, 1'b0);
`ifdef CORDIC_SEQ_STATS_EN
      check("ar_stat_dropped", stat_dropped, 16'h0);
`endif
      req_valid = 1'b0; rsp_ready = 1'b0;
      step(); step();
      reset = 1'b1;
      exp_q.delete();
      run_single(16'h0AAA, 16'h0555, 16'h0C3C, 1'b0, 16'h0AAB, 16'h0557);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
